// File: rtl/bram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_arb_pkg
// Purpose  : Shared types and helpers for the BRAM port arbiter. This covers
//            the requester identity, the in-flight read tag, and the check for
//            legal RAM read-latency settings.
// Revision : 1.0 - initial release
// ============================================================================
package bram_arb_pkg;

    // Requester that owns a RAM command.
    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    // Tag that travels alongside each RAM command. The valid bit is set for reads only.
    typedef struct packed {
        logic  valid;
        port_e port;
    } tag_t;

    localparam int unsigned LAT_LOW_LATENCY      = 1;
    localparam int unsigned LAT_HIGH_PERFORMANCE = 2;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, port: PORT_A};

    // The RAM primitive supports two en-to-dout latencies. Any other value is illegal.
    function automatic bit read_latency_legal(input int unsigned lat);
        return (lat == LAT_LOW_LATENCY) || (lat == LAT_HIGH_PERFORMANCE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_arb_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bram_arb_tag_pipe
// Purpose  : Shift register of command tags. A tag that is pushed in the accept
//            cycle reaches the head exactly DEPTH_STAGES cycles later. At that
//            point it lines up with the RAM output data for that command.
// Ports    : clk   - clock (rising edge)
//            rst_n - asynchronous active-low clear (all stages idle)
//            push  - tag entering the pipe this cycle
//            head  - oldest tag (last stage)
// Revision : 1.0 - initial release
// ============================================================================
module bram_arb_tag_pipe
    import bram_arb_pkg::*;
#(
    parameter int DEPTH_STAGES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t push,
    output tag_t head
);

    generate
        if (DEPTH_STAGES < 1) begin : g_bad_depth
            $error("bram_arb_tag_pipe: DEPTH_STAGES must be at least 1");
        end
    endgenerate

    tag_t r_stage [DEPTH_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_STAGES; i++) begin
                r_stage[i] <= TAG_IDLE;
            end
        end else begin
            r_stage[0] <= push;
            for (int i = 1; i < DEPTH_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign head = r_stage[DEPTH_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_arbiter
// Purpose  : Lets two requesters share one single-port read-first BRAM.
//            Port A (pixel fetch) is read-only and has fixed high priority.
//            Port B (host/debug) can read and write.
//            The winning command is registered into the RAM. A tag pipe tracks
//            in-flight reads so that ram_dout is routed back as per-port rvalid.
// Config   : `define BRAM_ARB_STARVE_GUARD_EN to enable the B starvation guard.
//            With the guard on, after MAX_WAIT blocked cycles, B gets one slot.
// Ports    : clk, rst_n                        - clock / async active-low reset
//            a_req, a_addr, a_ready            - A read request / handshake
//            a_rdata, a_rvalid                 - A read return
//            b_req, b_we, b_addr, b_wdata      - B request
//            b_ready, b_rdata, b_rvalid        - B handshake / read return
//            ram_addr, ram_din, ram_we, ram_en - registered RAM command
//            ram_regce                         - RAM output register enable
//            ram_dout                          - RAM read data
// Revision : 1.0 - initial release
// ============================================================================
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter  int DATA_W       = 18,
    parameter  int DEPTH        = 1024,
    parameter  int READ_LATENCY = 2,
    parameter  int MAX_WAIT     = 8,
    localparam int ADDR_W       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_ready,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ready,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    output logic              ram_en,
    output logic              ram_regce,
    input  logic [DATA_W-1:0] ram_dout
);

    generate
        if (!read_latency_legal(READ_LATENCY)) begin : g_bad_latency
            $error("bram_port_arbiter: READ_LATENCY must be 1 or 2");
        end
        if (MAX_WAIT < 1) begin : g_bad_wait
            $error("bram_port_arbiter: MAX_WAIT must be at least 1");
        end
    endgenerate

    logic              r_run;      // low while in reset, so both readies are 0
    logic              r_ram_en;
    logic              r_ram_we;
    logic              r_regce;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_din;
    logic              w_force_b;  // starvation guard grants B this cycle
    logic              w_acc_a;
    logic              w_acc_b;
    tag_t              w_push;
    tag_t              w_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

`ifdef BRAM_ARB_STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_wait;

    assign w_force_b = (r_wait == WAIT_MAX);

    // Counts the cycles in which B is blocked. The counter saturates, and it
    // clears as soon as B is served or B withdraws its request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= '0;
        end else if (!b_req || w_acc_b) begin
            r_wait <= '0;
        end else if (r_wait != WAIT_MAX) begin
            r_wait <= r_wait + 1'b1;
        end
    end
`else
    assign w_force_b = 1'b0;
`endif

    // The grant is purely combinational. A wins a tie unless the guard forces a B slot.
    assign a_ready = r_run & ~w_force_b;
    assign b_ready = r_run & (~a_req | w_force_b);
    assign w_acc_a = a_req & a_ready;
    assign w_acc_b = b_req & b_ready;

    // Command register. When there is no accept, addr and din hold their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_en   <= 1'b0;
            r_ram_we   <= 1'b0;
            r_regce    <= 1'b0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
        end else begin
            r_regce  <= 1'b1;
            r_ram_en <= w_acc_a | w_acc_b;
            r_ram_we <= w_acc_b & b_we;
            if (w_acc_b) begin
                r_ram_addr <= b_addr;
                r_ram_din  <= b_wdata;
            end else if (w_acc_a) begin
                r_ram_addr <= a_addr;
            end
        end
    end

    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_regce = r_regce;
    assign ram_addr  = r_ram_addr;
    assign ram_din   = r_ram_din;

    // A write still occupies a pipe slot but carries valid=0. This drops the
    // read-first old data that the RAM returns for a write.
    assign w_push.valid = w_acc_a | (w_acc_b & ~b_we);
    assign w_push.port  = w_acc_b ? PORT_B : PORT_A;

    // One stage covers the command register, and READ_LATENCY stages cover the RAM.
    bram_arb_tag_pipe #(
        .DEPTH_STAGES(READ_LATENCY + 1)
    ) u_tag_pipe (
        .clk  (clk),
        .rst_n(rst_n),
        .push (w_push),
        .head (w_head)
    );

    assign a_rvalid = w_head.valid & (w_head.port == PORT_A);
    assign b_rvalid = w_head.valid & (w_head.port == PORT_B);
    assign a_rdata  = ram_dout;
    assign b_rdata  = ram_dout;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bram_port_arbiter
// Purpose  : Self-checking bench for bram_port_arbiter. It contains a
//            behavioural read-first BRAM (latency 2) and a queue scoreboard of
//            expected read returns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

    localparam int DATA_W       = 18;
    localparam int DEPTH        = 1024;
    localparam int ADDR_W       = 10;
    localparam int READ_LATENCY = 2;
    localparam int MAX_WAIT     = 8;

`ifdef BRAM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n = 1'b0;
    logic              a_req = 1'b0;
    logic [ADDR_W-1:0] a_addr = '0;
    logic              a_ready;
    logic [DATA_W-1:0] a_rdata;
    logic              a_rvalid;
    logic              b_req = 1'b0;
    logic              b_we = 1'b0;
    logic [ADDR_W-1:0] b_addr = '0;
    logic [DATA_W-1:0] b_wdata = '0;
    logic              b_ready;
    logic [DATA_W-1:0] b_rdata;
    logic              b_rvalid;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_we;
    logic              ram_en;
    logic              ram_regce;
    logic [DATA_W-1:0] ram_dout;

    bram_port_arbiter #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .READ_LATENCY(READ_LATENCY),
        .MAX_WAIT    (MAX_WAIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_req    (a_req),
        .a_addr   (a_addr),
        .a_ready  (a_ready),
        .a_rdata  (a_rdata),
        .a_rvalid (a_rvalid),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_ready  (b_ready),
        .b_rdata  (b_rdata),
        .b_rvalid (b_rvalid),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_en   (ram_en),
        .ram_regce(ram_regce),
        .ram_dout (ram_dout)
    );

    // Read-first BRAM with an output register: en to dout takes 2 cycles.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q1 = '0;
    logic [DATA_W-1:0] ram_q2 = '0;
    always @(posedge clk) begin
        if (ram_en) begin
            ram_q1 <= mem[ram_addr];
            if (ram_we) mem[ram_addr] <= ram_din;
        end
        if (ram_regce) ram_q2 <= ram_q1;
    end
    assign ram_dout = ram_q2;

    typedef struct {
        bit                port;   // 0 = A, 1 = B
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              sb[$];
    exp_t              mon_e;
    logic [DATA_W-1:0] shadow [DEPTH];
    logic [DATA_W-1:0] mon_data;
    int                checks = 0;
    int                failures = 0;
    bit                last_a_acc, last_b_acc;
    bit                obs_a_rv, obs_b_rv;

    // Scoreboard: every rvalid pulse must match the oldest outstanding read.
    always @(negedge clk) begin
        if (a_rvalid === 1'b1 && b_rvalid === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL rvalid_both: a_rvalid=1 b_rvalid=1, required at most one");
        end else if (a_rvalid === 1'b1 || b_rvalid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL rvalid_unexpected: a_rvalid=%0b b_rvalid=%0b, required none outstanding",
                         a_rvalid, b_rvalid);
            end else begin
                mon_e    = sb.pop_front();
                mon_data = b_rvalid ? b_rdata : a_rdata;
                if (b_rvalid !== mon_e.port || mon_data !== mon_e.data) begin
                    failures++;
                    $display("FAIL return_order: got port=%0d data=%05h, required port=%0d data=%05h",
                             b_rvalid, mon_data, mon_e.port, mon_e.data);
                end
            end
        end
    end

    // Drives one cycle of stimulus at the falling edge. It records the observed
    // handshake and pushes expected read data from the shadow memory.
    task automatic cyc(input bit ar, input logic [ADDR_W-1:0] aa, input bit br, input bit bw,
                       input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
        exp_t e;
        @(negedge clk);
        obs_a_rv = (a_rvalid === 1'b1);
        obs_b_rv = (b_rvalid === 1'b1);
        a_req = ar; a_addr = aa; b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        #1;
        last_a_acc = ar && (a_ready === 1'b1);
        last_b_acc = br && (b_ready === 1'b1);
        if (last_a_acc) begin
            e.port = 1'b0; e.data = shadow[aa];
            sb.push_back(e);
        end
        if (last_b_acc) begin
            if (bw) begin
                shadow[ba] = bd;
            end else begin
                e.port = 1'b1; e.data = shadow[ba];
                sb.push_back(e);
            end
        end
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 10'h001, 1'b1, 1'b0, 10'h002, '0);
            checks++;
            if ({a_ready, b_ready, a_rvalid, b_rvalid, ram_en, ram_we, ram_regce, ram_addr, ram_din} !== '0) begin
                failures++;
                $display("FAIL reset_outputs: rdy=%b%b rv=%b%b en=%b we=%b regce=%b addr=%h din=%h, required all 0",
                         a_ready, b_ready, a_rvalid, b_rvalid, ram_en, ram_we, ram_regce, ram_addr, ram_din);
            end
        end
        @(negedge clk);
        a_req = 1'b0; b_req = 1'b0;
        rst_n = 1'b1;
        idle();
        idle();
        checks++;
        if (ram_en !== 1'b0 || ram_regce !== 1'b1 || a_ready !== 1'b1 || b_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: en=%b regce=%b a_ready=%b b_ready=%b, required en=0 regce=1 ready=1/1",
                     ram_en, ram_regce, a_ready, b_ready);
        end
    endtask

    task automatic test_lone_a_read();
        cyc(1'b1, 10'h005, 1'b0, 1'b0, '0, '0);
        checks++;
        if (a_ready !== 1'b1) begin
            failures++;
            $display("FAIL lone_a_ready: a_ready=%b, required 1", a_ready);
        end
        idle();
        checks++;
        if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 10'h005) begin
            failures++;
            $display("FAIL lone_a_cmd: en=%b we=%b addr=%h, required en=1 we=0 addr=005", ram_en, ram_we, ram_addr);
        end
        idle();
        checks++;
        if (a_rvalid !== 1'b0 || ram_en !== 1'b0) begin
            failures++;
            $display("FAIL lone_a_early: a_rvalid=%b ram_en=%b at N+2, required 0/0", a_rvalid, ram_en);
        end
        idle();
        checks++;
        if (a_rvalid !== 1'b1 || b_rvalid !== 1'b0 || a_rdata !== 18'h2AAAA) begin
            failures++;
            $display("FAIL lone_a_return: a_rvalid=%b b_rvalid=%b a_rdata=%05h, required 1/0/2aaaa",
                     a_rvalid, b_rvalid, a_rdata);
        end
        idle();
    endtask

    task automatic test_b_write_read();
        int pulses = 0;
        int at = -1;
        logic [DATA_W-1:0] got = '0;
        cyc(1'b0, '0, 1'b1, 1'b1, 10'h010, 18'h01234);
        checks++;
        if (b_ready !== 1'b1) begin
            failures++;
            $display("FAIL b_write_ready: b_ready=%b, required 1", b_ready);
        end
        cyc(1'b0, '0, 1'b1, 1'b0, 10'h010, '0);
        checks++;
        if (b_ready !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 10'h010 || ram_din !== 18'h01234) begin
            failures++;
            $display("FAIL b_write_cmd: rdy=%b en=%b we=%b addr=%h din=%05h, required 1/1/1/010/01234",
                     b_ready, ram_en, ram_we, ram_addr, ram_din);
        end
        for (int i = 1; i <= 6; i++) begin
            idle();
            if (obs_b_rv || obs_a_rv) begin
                pulses++;
                at = i;
                got = b_rdata;
            end
        end
        checks++;
        if (pulses != 1 || at != 3 || got !== 18'h01234) begin
            failures++;
            $display("FAIL b_readback: pulses=%0d at=%0d data=%05h, required 1 pulse at 3 data=01234", pulses, at, got);
        end
    endtask

    task automatic test_starvation();
        bit exp_b;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 10'h007, 1'b1, 1'b0, 10'h020, '0);
            exp_b = GUARD && (i == MAX_WAIT || i == 2 * MAX_WAIT + 1);
            checks++;
            if (a_ready !== !exp_b || b_ready !== exp_b) begin
                failures++;
                $display("FAIL starve_grant: cycle=%0d a_ready=%b b_ready=%b, required %b/%b",
                         i, a_ready, b_ready, !exp_b, exp_b);
            end
        end
        for (int i = 0; i < 6; i++) idle();
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int first = -1;
        int last = -1;
        for (int i = 0; i < 22; i++) begin
            if (i < 16) begin
                cyc(i % 2 == 0, 10'(10'h040 + i), i % 2 == 1, 1'b0, 10'(10'h040 + i), '0);
                checks++;
                if ((i % 2 == 0 && !last_a_acc) || (i % 2 == 1 && !last_b_acc)) begin
                    failures++;
                    $display("FAIL b2b_accept: cycle=%0d a_acc=%b b_acc=%b, required the issuing port accepted",
                             i, last_a_acc, last_b_acc);
                end
            end else begin
                idle();
            end
            if (obs_a_rv || obs_b_rv) begin
                pulses++;
                if (first < 0) first = i;
                last = i;
            end
        end
        checks++;
        if (pulses != 16 || first != 3 || last != 18) begin
            failures++;
            $display("FAIL b2b_stream: pulses=%0d first=%0d last=%0d, required 16 pulses from 3 to 18",
                     pulses, first, last);
        end
    endtask

    task automatic test_reset_mid_flight();
        int pulses = 0;
        cyc(1'b1, 10'h003, 1'b0, 1'b0, '0, '0);
        cyc(1'b0, '0, 1'b1, 1'b0, 10'h004, '0);
        checks++;
        if (!last_b_acc || sb.size() != 2) begin
            failures++;
            $display("FAIL midrst_setup: b_acc=%b outstanding=%0d, required 1/2", last_b_acc, sb.size());
        end
        @(negedge clk);
        rst_n = 1'b0;
        a_req = 1'b0; b_req = 1'b0;
        sb.delete();
        @(negedge clk);
        if (a_rvalid === 1'b1 || b_rvalid === 1'b1) pulses++;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            idle();
            if (obs_a_rv || obs_b_rv) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL midrst_drop: rvalid pulses=%0d, required 0", pulses);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]    = DATA_W'((i * 37) ^ 'h15555);
            shadow[i] = DATA_W'((i * 37) ^ 'h15555);
        end
        mem[5]    = 18'h2AAAA;
        shadow[5] = 18'h2AAAA;

        test_reset();
        test_lone_a_read();
        test_b_write_read();
        test_starvation();
        test_back_to_back();
        test_reset_mid_flight();

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: outstanding=%0d, required 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
